barrel_unshifter: RTL
=====================

# barrel_unshifter

Pipelined inverse rotator for `ndata_i` tuples. Undoes the normalization rotation: each input tuple comes with a per-tuple `offset`, and the block rotates elements toward lower indices by that offset (`out.data[j] = in.data[(j + offset) mod NUM_ELEMENTS]`). It sits on the de-normalization path, after processing of normalized tuples, and restores the original element order. Full valid/ready backpressure is supported, and the pipeline depth is configurable.

## Interface
- `data_t`, no default: element type.
- `NUM_ELEMENTS`, no default: tuple width N. Must be a power of two and ≥1; any other value is an elaboration error.
- `REGISTER_LEVELS`, default 0: number of pipeline registers inside the rotator. 0 means fully combinational. Clamped to S = $clog2(N).
- `OFFSET_WIDTH`, default $clog2(NUM_ELEMENTS): width of the offset input. Bits at position S and above are ignored.
- `clk`, input, 1: sole clock.
- `rst_n`, input, 1: asynchronous, active-low reset.
- `offset`, input, OFFSET_WIDTH: rotation amount. Sampled together with `in` on each accepted beat.
- `in`, ndata_i.s, N×data_t: input tuples. Carries data, keep, last, valid, ready.
- `out`, ndata_i.m, N×data_t: rotated tuples.

## Operation
- The rotator has S logarithmic stages. Stage k rotates by 2^k toward lower indices when bit k of the offset travelling with that tuple is set. Otherwise it passes the tuple through unchanged.
- `keep` bits are rotated identically to `data`. `last` passes through unrotated.
- Register placement: G = ceil(S/R), where R = min(REGISTER_LEVELS, S). A register follows stage k when R>0 and (k+1) % G == 0. Register count L equals the number of such positions.
- Each register holds data, keep, last, the remaining offset bits, and a valid flag.
- Backpressure, per register level r:
  - `ready_r` = (downstream ready) OR NOT valid_r. Bubbles collapse.
  - `in.ready` = `ready` of the first level. With L=0, `in.ready` = `out.ready`.
  - A level loads when upstream is valid and `ready_r` is high. Its valid bit clears when it drains with no new load.
- Transfer rules: no beat is dropped or duplicated. Order is preserved. `last` is aligned to its own beat.
- N=1: S=0, pure pass-through. Offset is ignored.

## Timing
- Reset values: all valid flags are 0, so `out.valid`=0. Data, keep and last registers go to 0. `in.ready`=1 from the first cycle after reset deassertion when L>0; it follows `out.ready` when L=0.
- Latency is L cycles from input handshake to `out.valid`, with macro off. Throughput is 1 tuple/cycle while `out.ready`=1.
- `out.valid` stays asserted, and `out` stays stable, until `out.ready` is sampled high.
- `out.ready` held low: the pipeline fills to exactly L beats, then `in.ready` drops combinationally in the same cycle.
- Simultaneous drain and load on a full level: both occur. No bubble is inserted.
- Reset asserted mid-operation: all in-flight beats are discarded immediately, asynchronously. No partial beat appears after reset.
- Offset is changeable every beat, and each beat uses only its own sampled offset.

## Configuration
- `BARREL_UNSHIFTER_OUTPUT_SKID_EN`:
  - Defined: a 2-entry skid buffer follows the rotator. `out` is driven from flops, and the ready path from `out.ready` to `in.ready` is fully registered. Latency becomes L+1; throughput stays 1/cycle. Skid entries reset to empty.
  - Undefined: no skid buffer. `out` comes directly from the last level, and `out.ready` combinationally reaches `in.ready`.

## Test plan
- N=8, REGISTER_LEVELS=1. Input data 0..7, keep=0xFF, offset=3 -> output [3,4,5,6,7,0,1,2], keep=0xFF, exactly 1 cycle after the input handshake.
- N=8, REGISTER_LEVELS=3. Stream 16 beats with offsets 0..7,0..7, `out.ready`=1 -> each beat rotated by its own offset, in order, latency 3, no bubbles.
- N=4. keep=0b0011, offset=1, `last`=1 -> keep=0b1001, `last`=1 on the same beat. `offset`=5 (OFFSET_WIDTH=3) -> behaves as offset 1.
- Random `out.ready` (50%), 1000 beats, compared against a reference model -> zero mismatches, no drop or duplicate, `out` stable while stalled.
- Assert `rst_n` low while 3 beats are in flight (REGISTER_LEVELS=3) -> `out.valid`=0 immediately, and only post-reset beats emerge afterwards.
- Macro defined, N=8, REGISTER_LEVELS=1 -> latency 2. With `out.ready` toggling each cycle, `in.ready` never depends combinationally on `out.ready` and no data is lost.

Source files
------------

// File: rtl/barrel_unshifter.sv
// Inverse rotator: out[j] = in[(j + offset) mod N] over log2(N) stages, optional pipeline registers, valid/ready.
// Define BARREL_UNSHIFTER_OUTPUT_SKID_EN to add a 2-entry output skid buffer (+1 cycle, ready path fully registered).
module barrel_unshifter #(
  parameter type data_t          = logic [7:0],
  parameter int  NUM_ELEMENTS    = 8,
  parameter int  REGISTER_LEVELS = 0,
  parameter int  OFFSET_WIDTH    = (NUM_ELEMENTS > 1) ? $clog2(NUM_ELEMENTS) : 1
) (
  input  logic                                  clk,
  input  logic                                  rst_n,
  input  logic [OFFSET_WIDTH-1:0]               offset,
  input  logic [NUM_ELEMENTS*$bits(data_t)-1:0] in_data,
  input  logic [NUM_ELEMENTS-1:0]               in_keep,
  input  logic                                  in_last,
  input  logic                                  in_valid,
  output logic                                  in_ready,
  output logic [NUM_ELEMENTS*$bits(data_t)-1:0] out_data,
  output logic [NUM_ELEMENTS-1:0]               out_keep,
  output logic                                  out_last,
  output logic                                  out_valid,
  input  logic                                  out_ready
);
  localparam int W  = $bits(data_t);
  localparam int N  = NUM_ELEMENTS;
  localparam int DW = N * W;
  localparam int S  = $clog2(N);
  localparam int OW = (S > 0) ? S : 1;
  localparam int R  = (REGISTER_LEVELS < S) ? REGISTER_LEVELS : S;
  localparam int G  = (R > 0) ? (S + R - 1) / R : 1;

  if (N < 1 || (N & (N - 1)) != 0) begin : g_bad_n
    $error("barrel_unshifter: NUM_ELEMENTS must be a power of two");
  end

  logic [DW-1:0]            core_data;
  logic [N-1:0]             core_keep;
  logic                     core_last;
  logic                     core_vld;
  logic                     core_rdy;
  logic [OW-1:0]            reg_vld;
  logic [OW+OFFSET_WIDTH-1:0] off_ext;
  logic                     unused_bits;

  // Offset bits at or above S never reach a stage.
  assign off_ext     = {{OW{1'b0}}, offset};
  assign unused_bits = ^off_ext;

  // A level is ready when anything from it to the output can advance.
  assign in_ready = core_rdy | ~&reg_vld;

  for (genvar k = 0; k < S; k++) begin : g_stage
    logic [DW-1:0] d_in, d_rot, d_out;
    logic [N-1:0]  k_in, k_rot, k_out;
    logic [OW-1:0] o_in, o_out;
    logic          l_in, l_out, v_in, v_out;

    if (k == 0) begin : g_first
      assign d_in = in_data;
      assign k_in = in_keep;
      assign o_in = off_ext[OW-1:0];
      assign l_in = in_last;
      assign v_in = in_valid;
    end else begin : g_next
      assign d_in = g_stage[k-1].d_out;
      assign k_in = g_stage[k-1].k_out;
      assign o_in = g_stage[k-1].o_out;
      assign l_in = g_stage[k-1].l_out;
      assign v_in = g_stage[k-1].v_out;
    end

    always_comb begin
      d_rot = d_in;
      k_rot = k_in;
      if (o_in[k]) begin
        for (int j = 0; j < N; j++) begin
          d_rot[j*W +: W] = d_in[((j + (1 << k)) % N)*W +: W];
          k_rot[j]        = k_in[(j + (1 << k)) % N];
        end
      end
    end

    if (R > 0 && ((k + 1) % G) == 0) begin : g_reg
      logic [DW-1:0] d_q;
      logic [N-1:0]  k_q;
      logic [OW-1:0] o_q;
      logic          l_q, v_q;
      logic          rdy;

      assign rdy = core_rdy | ~&reg_vld[S-1:k];

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          d_q <= '0;
          k_q <= '0;
          o_q <= '0;
          l_q <= 1'b0;
          v_q <= 1'b0;
        end else if (rdy) begin
          v_q <= v_in;
          if (v_in) begin
            d_q <= d_rot;
            k_q <= k_rot;
            o_q <= o_in;
            l_q <= l_in;
          end
        end
      end

      assign d_out      = d_q;
      assign k_out      = k_q;
      assign o_out      = o_q;
      assign l_out      = l_q;
      assign v_out      = v_q;
      assign reg_vld[k] = v_q;
    end else begin : g_comb
      assign d_out      = d_rot;
      assign k_out      = k_rot;
      assign o_out      = o_in;
      assign l_out      = l_in;
      assign v_out      = v_in;
      assign reg_vld[k] = 1'b1;
    end
  end

  if (S > 0) begin : g_core
    logic unused_tail;
    assign core_data   = g_stage[S-1].d_out;
    assign core_keep   = g_stage[S-1].k_out;
    assign core_last   = g_stage[S-1].l_out;
    assign core_vld    = g_stage[S-1].v_out;
    assign unused_tail = ^g_stage[S-1].o_out;
  end else begin : g_pass
    assign core_data = in_data;
    assign core_keep = in_keep;
    assign core_last = in_last;
    assign core_vld  = in_valid;
    assign reg_vld   = '1;
  end

`ifdef BARREL_UNSHIFTER_OUTPUT_SKID_EN
  localparam int EW = DW + N + 1;
  logic [EW-1:0] sk_e0, sk_e1, sk_in;
  logic [1:0]    sk_cnt;
  logic          sk_push, sk_pop;

  // Ready depends only on the fill count, so out_ready never reaches in_ready.
  assign core_rdy = (sk_cnt != 2'd2);
  assign sk_in    = {core_last, core_keep, core_data};
  assign sk_push  = core_vld & core_rdy;
  assign sk_pop   = out_valid & out_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sk_e0  <= '0;
      sk_e1  <= '0;
      sk_cnt <= 2'd0;
    end else begin
      case ({sk_push, sk_pop})
        2'b10: begin
          if (sk_cnt == 2'd0) sk_e0 <= sk_in;
          else                sk_e1 <= sk_in;
          sk_cnt <= sk_cnt + 2'd1;
        end
        2'b01: begin
          sk_e0  <= sk_e1;
          sk_cnt <= sk_cnt - 2'd1;
        end
        2'b11:   sk_e0 <= sk_in;
        default: ;
      endcase
    end
  end

  assign out_valid = (sk_cnt != 2'd0);
  assign out_data  = sk_e0[DW-1:0];
  assign out_keep  = sk_e0[DW +: N];
  assign out_last  = sk_e0[EW-1];
`else
  assign core_rdy  = out_ready;
  assign out_valid = core_vld;
  assign out_data  = core_data;
  assign out_keep  = core_keep;
  assign out_last  = core_last;
`endif

endmodule
